// File: rtl/switch_debouncer_pkg.sv
// ============================================================================
// Module   : sw_io_pkg
// Purpose  : Shared constants and helpers for the board-switch conditioning
//            path (synchroniser + per-bit debounce).
// Contents : SW_WIDTH         default number of switch bits
//            DEFAULT_CNT_MAX  default debounce interval in clock cycles
//                             (10 ms at 100 MHz)
//            cnt_width()      width of a counter holding 0..cnt_max
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sw_io_pkg;

    localparam int SW_WIDTH        = 16;
    localparam int DEFAULT_CNT_MAX = 1_000_000;

    // Width needed to represent 0..cnt_max. A nonsensical cnt_max below 1
    // still yields a legal 1-bit counter so elaboration never collapses to
    // a zero-width vector.
    function automatic int cnt_width(input int cnt_max);
        if (cnt_max < 1) begin
            return 1;
        end
        return $clog2(cnt_max + 1);
    endfunction

endpackage : sw_io_pkg

`default_nettype wire

// File: rtl/switch_debouncer_if.sv
// ============================================================================
// Module   : switch_debouncer_if
// Purpose  : Bundles the switch-conditioning signals exchanged between the
//            board-level logic (master) and the debouncer (slave).
// Signals  : sw_raw           raw asynchronous switch pins       (master->slave)
//            evt_clr          write-one-to-clear for sw_event    (master->slave)
//            io_rdata_switch  debounced stable switch word       (slave->master)
//            sw_rise          one-cycle accepted 0->1 pulses     (slave->master)
//            sw_fall          one-cycle accepted 1->0 pulses     (slave->master)
//            sw_changed       OR of all rise/fall pulses         (slave->master)
//            sw_event         sticky per-bit change flags        (slave->master)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface switch_debouncer_if
    import sw_io_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
);

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] evt_clr;
    logic [WIDTH-1:0] io_rdata_switch;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;
    logic [WIDTH-1:0] sw_event;

    // Board side: drives the pins and the clear strobe, consumes the results.
    modport master (
        output sw_raw,
        output evt_clr,
        input  io_rdata_switch,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed,
        input  sw_event
    );

    // Debouncer side.
    modport slave (
        input  sw_raw,
        input  evt_clr,
        output io_rdata_switch,
        output sw_rise,
        output sw_fall,
        output sw_changed,
        output sw_event
    );

endinterface : switch_debouncer_if

`default_nettype wire

// File: rtl/switch_debouncer_debounce_bit.sv
// ============================================================================
// Module   : debounce_bit
// Purpose  : Debounces one already-synchronised switch bit. A new level is
//            accepted only after it has differed from the current stable
//            value for CNT_MAX consecutive clock edges; any return to the
//            stable value before then discards the progress.
// Ports    : clk       system clock (posedge)
//            rst_n     asynchronous active-low reset
//            s2_i      synchronised switch bit
//            stable_o  accepted (debounced) level, registered
//            rise_o    one-cycle pulse, registered, on accepted 0->1
//            fall_o    one-cycle pulse, registered, on accepted 1->0
// Params   : CNT_MAX   consecutive differing edges required (>= 1)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce_bit
    import sw_io_pkg::*;
#(
    parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s2_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CNT_W    = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // The counter only ever advances while the input differs from the stable
    // level and is cleared on acceptance, so it never passes CNT_LAST.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;

        if (s2_i == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Acceptance: the pulse is registered on the same edge as the
            // new stable level so both appear together.
            stable_d = s2_i;
            cnt_d    = '0;
            rise_d   = s2_i;
            fall_d   = ~s2_i;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule : debounce_bit

`default_nettype wire

// File: rtl/switch_debouncer.sv
// ============================================================================
// Module   : switch_debouncer
// Purpose  : Conditions the raw board switches for the data-memory MMIO
//            read path: two-flop synchroniser, per-bit debounce, one-cycle
//            rise/fall pulses, a combined change flag and optional sticky
//            per-bit event flags.
// Ports    : clk    system clock (posedge)
//            rst_n  asynchronous active-low reset
//            sw     switch_debouncer_if.slave
//                     sw_raw / evt_clr in,
//                     io_rdata_switch / sw_rise / sw_fall / sw_changed /
//                     sw_event out
// Params   : WIDTH    number of switch bits
//            CNT_MAX  debounce interval in clock cycles (>= 1)
// Config   : SW_STICKY_EN  when defined, sw_event holds sticky change flags
//                          cleared by evt_clr (set wins over clear); when
//                          undefined, sw_event is 0 and evt_clr is ignored.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module switch_debouncer
    import sw_io_pkg::*;
#(
    parameter int WIDTH   = SW_WIDTH,
    parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    switch_debouncer_if.slave  sw
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // Two-flop synchroniser; only the second stage is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw.sw_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CNT_MAX (CNT_MAX)
        ) u_debounce_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .s2_i     (sync2_q[i]),
            .stable_o (stable[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

    assign sw.io_rdata_switch = stable;
    assign sw.sw_rise         = rise;
    assign sw.sw_fall         = fall;
    // Reduction of already-registered pulses: same cycle as the pulses and
    // no path back to the raw pins.
    assign sw.sw_changed      = |(rise | fall);

`ifdef SW_STICKY_EN
    logic [WIDTH-1:0] event_q;
    logic [WIDTH-1:0] event_d;

    // Clear first, then OR in new pulses so a set in the same cycle wins.
    always_comb begin
        event_d = (event_q & ~sw.evt_clr) | rise | fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q <= '0;
        end else begin
            event_q <= event_d;
        end
    end

    assign sw.sw_event = event_q;
`else
    // Port kept for a stable top level; the clear strobe has no effect.
    logic unused_evt_clr;
    assign unused_evt_clr = ^sw.evt_clr;
    assign sw.sw_event    = '0;
`endif

endmodule : switch_debouncer

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// ============================================================================
// Module   : tb_switch_debouncer
// Purpose  : Self-checking bench for switch_debouncer with CNT_MAX = 4.
//            Hand sequences for reset/latency/sticky corners, a vector table
//            of held input words with expected end state and pulse counts,
//            and a randomized run compared every cycle against a window
//            reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_switch_debouncer;
    import sw_io_pkg::*;

    localparam int W  = 16;
    localparam int CM = 4;
`ifdef SW_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    switch_debouncer_if #(.WIDTH(W)) sw_if ();

    switch_debouncer #(
        .WIDTH   (W),
        .CNT_MAX (CM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model --------------------------------------
    // The debouncer sees the pin value from two edges earlier. A bit is
    // accepted when the last CM seen values all differ from its stable level.
    logic [W-1:0] m_dly [2];
    logic [W-1:0] m_win [CM];
    logic [W-1:0] m_stable, m_rise, m_fall, m_event;

    function automatic void model_reset();
        m_dly[0] = '0; m_dly[1] = '0;
        for (int i = 0; i < CM; i++) m_win[i] = '0;
        m_stable = '0; m_rise = '0; m_fall = '0; m_event = '0;
    endfunction

    function automatic void model_edge(input logic [W-1:0] raw, input logic [W-1:0] clr);
        logic [W-1:0] seen, acc, ev_next;
        seen     = m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = raw;
        for (int i = CM - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = seen;
        ev_next  = STICKY ? ((m_event & ~clr) | m_rise | m_fall) : '0;
        acc = '1;
        for (int i = 0; i < CM; i++) acc &= (m_win[i] ^ m_stable);
        m_rise   = acc & ~m_stable;
        m_fall   = acc & m_stable;
        m_stable = m_stable ^ acc;
        m_event  = ev_next;
    endfunction

    // ---------------- checking helpers -------------------------------------
    task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        do_check({tag, ".word"},    32'(sw_if.io_rdata_switch), 32'(m_stable));
        do_check({tag, ".rise"},    32'(sw_if.sw_rise),         32'(m_rise));
        do_check({tag, ".fall"},    32'(sw_if.sw_fall),         32'(m_fall));
        do_check({tag, ".changed"}, 32'(sw_if.sw_changed),      32'(|(m_rise | m_fall)));
        do_check({tag, ".event"},   32'(sw_if.sw_event),        32'(m_event));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_edge(sw_if.sw_raw, sw_if.evt_clr);
        else       model_reset();
        #1;
        compare_all(tag);
    endtask

    // Assert reset (async), check, hold two edges, release mid-cycle.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        do_check({tag, ".rst_word"}, 32'(sw_if.io_rdata_switch), 32'h0);
        tick(tag);
        tick(tag);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table -----------------------------------------
    typedef struct {
        logic [W-1:0] raw;
        int           cycles;
        logic [W-1:0] exp_word;
        logic [W-1:0] exp_rise;
        logic [W-1:0] exp_fall;
        int           exp_npulse;
    } vec_t;

    localparam int NVEC = 16;
    vec_t tbl [NVEC];

    initial begin
        logic [W-1:0] acc_r, acc_f, lfsr_raw;
        int npulse;

        tbl[0]  = '{16'h0001, 3, 16'h0000, 16'h0000, 16'h0000, 0}; // short glitch
        tbl[1]  = '{16'h0000, 6, 16'h0000, 16'h0000, 16'h0000, 0};
        tbl[2]  = '{16'h0008, 1, 16'h0000, 16'h0000, 16'h0000, 0}; // bit3 bouncing
        tbl[3]  = '{16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0};
        tbl[4]  = '{16'h0008, 1, 16'h0000, 16'h0000, 16'h0000, 0};
        tbl[5]  = '{16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0};
        tbl[6]  = '{16'h0008, 1, 16'h0000, 16'h0000, 16'h0000, 0};
        tbl[7]  = '{16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0};
        tbl[8]  = '{16'h0008, 8, 16'h0008, 16'h0008, 16'h0000, 1}; // one rise
        tbl[9]  = '{16'h8001, 8, 16'h8001, 16'h8001, 16'h0008, 1};
        tbl[10] = '{16'h0003, 8, 16'h0003, 16'h0002, 16'h8000, 1}; // rise+fall same cycle
        tbl[11] = '{16'h0000, 3, 16'h0003, 16'h0000, 16'h0000, 0};
        tbl[12] = '{16'h0003, 8, 16'h0003, 16'h0000, 16'h0000, 0}; // CM-1 run discarded
        tbl[13] = '{16'hFFFF, 6, 16'hFFFF, 16'hFFFC, 16'h0000, 1}; // exact latency
        tbl[14] = '{16'h0000, 5, 16'hFFFF, 16'h0000, 16'h0000, 0}; // one edge short
        tbl[15] = '{16'h0000, 1, 16'h0000, 16'h0000, 16'hFFFF, 1}; // accepted now

        sw_if.sw_raw  = 16'hFFFF;
        sw_if.evt_clr = '0;
        model_reset();
        #2;

        // ---- 1: reset with all switches high, then latency after release
        do_reset("t1");
        for (int e = 1; e <= 7; e++) begin
            tick("t1");
            if (e < 6) do_check("t1.word_before", 32'(sw_if.io_rdata_switch), 32'h0000);
            if (e == 6) begin
                do_check("t1.word_accept", 32'(sw_if.io_rdata_switch), 32'hFFFF);
                do_check("t1.rise_accept", 32'(sw_if.sw_rise), 32'hFFFF);
                do_check("t1.changed",     32'(sw_if.sw_changed), 32'h1);
            end
            if (e == 7) begin
                do_check("t1.rise_after",    32'(sw_if.sw_rise), 32'h0000);
                do_check("t1.changed_after", 32'(sw_if.sw_changed), 32'h0);
            end
        end

        // ---- 2..4 and boundaries: vector table
        sw_if.sw_raw = '0;
        do_reset("tbl_rst");
        for (int v = 0; v < NVEC; v++) begin
            sw_if.sw_raw = tbl[v].raw;
            acc_r = '0; acc_f = '0; npulse = 0;
            for (int c = 0; c < tbl[v].cycles; c++) begin
                tick("tbl");
                acc_r |= sw_if.sw_rise;
                acc_f |= sw_if.sw_fall;
                if (sw_if.sw_changed) npulse++;
            end
            do_check($sformatf("tbl%0d.word", v),   32'(sw_if.io_rdata_switch), 32'(tbl[v].exp_word));
            do_check($sformatf("tbl%0d.rise", v),   32'(acc_r), 32'(tbl[v].exp_rise));
            do_check($sformatf("tbl%0d.fall", v),   32'(acc_f), 32'(tbl[v].exp_fall));
            do_check($sformatf("tbl%0d.npulse", v), 32'(npulse), 32'(tbl[v].exp_npulse));
        end

        // ---- 5: reset mid-count discards progress
        sw_if.sw_raw = '0;
        do_reset("t5_rst");
        sw_if.sw_raw = 16'h0080;
        for (int e = 0; e < 3; e++) begin
            tick("t5_pre");
            do_check("t5.no_pulse", 32'(sw_if.sw_changed), 32'h0);
        end
        do_reset("t5_mid");
        for (int e = 1; e <= 6; e++) begin
            tick("t5");
            if (e == 5) do_check("t5.word_early", 32'(sw_if.io_rdata_switch), 32'h0000);
            if (e == 6) begin
                do_check("t5.word", 32'(sw_if.io_rdata_switch), 32'h0080);
                do_check("t5.rise", 32'(sw_if.sw_rise), 32'h0080);
            end
        end

        // ---- 6: sticky event flag, set wins over same-cycle clear
        sw_if.sw_raw = '0;
        do_reset("t6_rst");
        sw_if.sw_raw = 16'h0004;
        for (int e = 1; e <= 6; e++) tick("t6");
        do_check("t6.rise", 32'(sw_if.sw_rise), 32'h0004);
        sw_if.evt_clr = 16'h0004;
        tick("t6");
        do_check("t6.event_set", 32'(sw_if.sw_event), STICKY ? 32'h0004 : 32'h0);
        tick("t6");
        do_check("t6.event_clr", 32'(sw_if.sw_event), 32'h0);
        sw_if.evt_clr = '0;

        // ---- randomized run against the model, with a reset in the middle
        lfsr_raw = '0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) lfsr_raw ^= W'($urandom) & W'($urandom);
            sw_if.sw_raw  = lfsr_raw;
            sw_if.evt_clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            if (n == 700) do_reset("rnd_rst");
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_switch_debouncer

`default_nettype wire
